// File: rtl/render_pkg.sv
// render_pkg: shared scheduler state type, colour struct and grid sizing helpers
package render_pkg;
  typedef enum logic [1:0] {ISSUE, WAIT, DONE} sched_state_t;
  localparam int RGB_BITS = 8;
  typedef struct packed {
    logic [RGB_BITS-1:0] r;
    logic [RGB_BITS-1:0] g;
    logic [RGB_BITS-1:0] b;
  } rgb_t;
  function automatic int coord_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int grid_aw(int w, int h, int s);
    return coord_w((w / s) * (h / s));
  endfunction
endpackage

// File: rtl/frame_scheduler_if.sv
// frame_scheduler_if: ray handshake, frame-buffer and display signals of the scheduler
interface frame_scheduler_if import render_pkg::*; #(
  parameter int WIDTH      = 1280,
  parameter int HEIGHT     = 720,
  parameter int SCALE      = 2,
  parameter int COLOR_BITS = 8
);
  localparam int RW = WIDTH / SCALE;
  localparam int RH = HEIGHT / SCALE;
  localparam int XW = coord_w(RW);
  localparam int YW = coord_w(RH);
  localparam int AW = grid_aw(WIDTH, HEIGHT, SCALE);
  localparam int DW = 3 * COLOR_BITS;
  logic [10:0]           hcount_in;
  logic [9:0]            vcount_in;
  logic                  new_frame_in;
  logic [XW-1:0]         ray_x_out;
  logic [YW-1:0]         ray_y_out;
  logic                  ray_valid_out;
  logic                  ray_ready_in;
  logic                  pix_valid_in;
  logic [DW-1:0]         pix_data_in;
  logic [AW:0]           wr_addr_out;
  logic [DW-1:0]         wr_data_out;
  logic                  wr_en_out;
  logic [AW:0]           rd_addr_out;
  logic [DW-1:0]         rd_data_in;
  logic [COLOR_BITS-1:0] red_out;
  logic [COLOR_BITS-1:0] green_out;
  logic [COLOR_BITS-1:0] blue_out;
  logic [15:0]           frame_count_out;
  logic                  busy_out;
  modport sched (
    input  hcount_in, vcount_in, new_frame_in, ray_ready_in, pix_valid_in, pix_data_in, rd_data_in,
    output ray_x_out, ray_y_out, ray_valid_out, wr_addr_out, wr_data_out, wr_en_out, rd_addr_out,
    output red_out, green_out, blue_out, frame_count_out, busy_out
  );
  modport env (
    output hcount_in, vcount_in, new_frame_in, ray_ready_in, pix_valid_in, pix_data_in, rd_data_in,
    input  ray_x_out, ray_y_out, ray_valid_out, wr_addr_out, wr_data_out, wr_en_out, rd_addr_out,
    input  red_out, green_out, blue_out, frame_count_out, busy_out
  );
endinterface

// File: rtl/frame_scheduler_fb_read_pipe.sv
// fb_read_pipe: up-scaled display read addressing with in-frame delay line and black-out mux
module fb_read_pipe import render_pkg::*; #(
  parameter int WIDTH      = 1280,
  parameter int HEIGHT     = 720,
  parameter int SCALE      = 2,
  parameter int COLOR_BITS = 8,
  parameter int RD_LATENCY = 2
)(
  input  logic                      clk_pixel_in,
  input  logic                      rst_in,
  input  logic [10:0]               hcount_i,
  input  logic [9:0]                vcount_i,
  input  logic                      disp_bank_i,
  input  logic                      shown_i,
  input  logic [3*COLOR_BITS-1:0]   rd_data_i,
  output logic [grid_aw(WIDTH, HEIGHT, SCALE):0] rd_addr_o,
  output logic [3*COLOR_BITS-1:0]   rgb_o
);
  localparam int RW = WIDTH / SCALE;
  localparam int LS = $clog2(SCALE);
  localparam int AW = grid_aw(WIDTH, HEIGHT, SCALE);
  localparam int DW = 3 * COLOR_BITS;
  logic          in_frame;
  logic [AW:0]   addr_d, addr_q;
  logic [RD_LATENCY:0] inf_q;
  logic [DW-1:0] rgb_d, rgb_q;
  assign in_frame = 32'(hcount_i) < WIDTH && 32'(vcount_i) < HEIGHT;
  assign addr_d = in_frame ? {disp_bank_i, AW'(hcount_i >> LS) + AW'(vcount_i >> LS) * AW'(RW)} : '0;
  // inf_q[RD_LATENCY] lines up with rd_data_i for the same pixel
  assign rgb_d = (inf_q[RD_LATENCY] && shown_i) ? rd_data_i : '0;
  always_ff @(posedge clk_pixel_in or negedge rst_in) begin
    if (!rst_in) begin
      addr_q <= '0;
      inf_q  <= '0;
      rgb_q  <= '0;
    end else begin
      addr_q <= addr_d;
      inf_q  <= {inf_q[RD_LATENCY-1:0], in_frame};
      rgb_q  <= rgb_d;
    end
  end
  assign rd_addr_o = addr_q;
  assign rgb_o = rgb_q;
endmodule

// File: rtl/frame_scheduler.sv
// frame_scheduler: walks the render grid over a ray handshake, writes the back bank,
// swaps banks only at a frame boundary and drives the display read path
module frame_scheduler import render_pkg::*; #(
  parameter int WIDTH      = 1280,
  parameter int HEIGHT     = 720,
  parameter int SCALE      = 2,
  parameter int COLOR_BITS = 8,
  parameter int RD_LATENCY = 2
)(
  input  logic              clk_pixel_in,
  input  logic              rst_in,
  frame_scheduler_if.sched  bus
);
  localparam int RW = WIDTH / SCALE;
  localparam int RH = HEIGHT / SCALE;
  localparam int XW = coord_w(RW);
  localparam int YW = coord_w(RH);
  localparam int AW = grid_aw(WIDTH, HEIGHT, SCALE);
  localparam int DW = 3 * COLOR_BITS;
  sched_state_t  state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          bank_q, bank_d, shown_q, shown_d, valid_q, wr_en_q, wr_en_d;
  logic [15:0]   fc_q, fc_d;
  logic [AW:0]   wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d, rgb;
  logic          x_end, last;
  assign x_end = x_q == XW'(RW - 1);
  assign last  = x_end && y_q == YW'(RH - 1);
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    bank_d    = bank_q;
    shown_d   = shown_q;
    fc_d      = fc_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      ISSUE: state_d = (valid_q && bus.ray_ready_in) ? WAIT : ISSUE;
      WAIT: if (bus.pix_valid_in) begin
        wr_en_d   = 1'b1;
        wr_addr_d = {bank_q, AW'(x_q) + AW'(y_q) * AW'(RW)};
        wr_data_d = bus.pix_data_in;
        x_d       = x_end ? '0 : x_q + 1'b1;
        y_d       = last ? '0 : x_end ? y_q + 1'b1 : y_q;
        state_d   = last ? DONE : ISSUE;
      end
      DONE: if (bus.new_frame_in) begin
        state_d = ISSUE;
        bank_d  = ~bank_q;
        shown_d = 1'b1;
        fc_d    = fc_q + 1'b1;
        x_d     = '0;
        y_d     = '0;
      end
      default: state_d = ISSUE;
    endcase
  end
  // valid is registered so it stays low through the reset cycle even though the state is ISSUE
  always_ff @(posedge clk_pixel_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= ISSUE;
      x_q       <= '0;
      y_q       <= '0;
      bank_q    <= 1'b0;
      shown_q   <= 1'b0;
      fc_q      <= '0;
      valid_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      bank_q    <= bank_d;
      shown_q   <= shown_d;
      fc_q      <= fc_d;
      valid_q   <= state_d == ISSUE;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end
  fb_read_pipe #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .SCALE(SCALE), .COLOR_BITS(COLOR_BITS), .RD_LATENCY(RD_LATENCY)
  ) u_read (
    .clk_pixel_in(clk_pixel_in),
    .rst_in      (rst_in),
    .hcount_i    (bus.hcount_in),
    .vcount_i    (bus.vcount_in),
    .disp_bank_i (~bank_q),
    .shown_i     (shown_q),
    .rd_data_i   (bus.rd_data_in),
    .rd_addr_o   (bus.rd_addr_out),
    .rgb_o       (rgb)
  );
  assign bus.ray_x_out       = x_q;
  assign bus.ray_y_out       = y_q;
  assign bus.ray_valid_out   = valid_q;
  assign bus.wr_en_out       = wr_en_q;
  assign bus.wr_addr_out     = wr_addr_q;
  assign bus.wr_data_out     = wr_data_q;
  assign bus.frame_count_out = fc_q;
  assign bus.busy_out        = state_q != DONE;
  assign {bus.red_out, bus.green_out, bus.blue_out} = rgb;
endmodule

// File: tb/tb_frame_scheduler.sv
// tb_frame_scheduler: random ray-core and display stimulus against a frame-level reference model
module tb_frame_scheduler;
  localparam int W = 16, H = 8, S = 2, CB = 8, NPIX = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  frame_scheduler_if #(.WIDTH(W), .HEIGHT(H), .SCALE(S), .COLOR_BITS(CB)) bus();
  frame_scheduler #(.WIDTH(W), .HEIGHT(H), .SCALE(S), .COLOR_BITS(CB), .RD_LATENCY(2)) dut (
    .clk_pixel_in(clk),
    .rst_in      (rst_n),
    .bus         (bus)
  );
  int vectors = 0;
  int errors = 0;
  logic [23:0] frames[4][NPIX];
  logic [23:0] mem[64];
  logic [5:0]  a1, a2;
  always @(posedge clk) begin
    if (bus.wr_en_out) mem[bus.wr_addr_out] <= bus.wr_data_out;
    a1 <= bus.rd_addr_out;
    a2 <= a1;
  end
  assign bus.rd_data_in = mem[a2];

  task automatic wait_valid(output bit ok);
    int n = 0;
    while (bus.ray_valid_out !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = bus.ray_valid_out === 1'b1;
  endtask

  task automatic test_reset();
    bus.hcount_in = 11'd100; bus.vcount_in = 10'd100; bus.new_frame_in = 1'b0;
    bus.ray_ready_in = 1'b0; bus.pix_valid_in = 1'b0; bus.pix_data_in = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (bus.ray_valid_out !== 1'b0) begin $display("FAIL reset_valid got %b want 0", bus.ray_valid_out); errors++; end
    vectors++; if (bus.wr_en_out !== 1'b0 || bus.wr_addr_out !== 6'd0 || bus.wr_data_out !== 24'd0) begin
      $display("FAIL reset_write got en=%b addr=%0d data=%h want 0/0/0", bus.wr_en_out, bus.wr_addr_out, bus.wr_data_out); errors++; end
    vectors++; if (bus.frame_count_out !== 16'd0 || bus.busy_out !== 1'b1) begin
      $display("FAIL reset_status got fc=%0d busy=%b want 0/1", bus.frame_count_out, bus.busy_out); errors++; end
    vectors++; if ({bus.red_out, bus.green_out, bus.blue_out} !== 24'd0 || bus.rd_addr_out !== 6'd0) begin
      $display("FAIL reset_display got rgb=%h rd_addr=%0d want 0/0", {bus.red_out, bus.green_out, bus.blue_out}, bus.rd_addr_out); errors++; end
    rst_n = 1'b1;
  endtask

  task automatic render_frame(input int k, input int nf_at, input bit nf_last);
    bit ok;
    logic [5:0] ea;
    for (int i = 0; i < NPIX; i++) begin
      wait_valid(ok);
      vectors++;
      if (!ok) begin $display("FAIL req_timeout frame %0d pixel %0d got valid=%b want 1", k, i, bus.ray_valid_out); errors++; return; end
      vectors++;
      if (bus.ray_x_out !== 3'(i % 8) || bus.ray_y_out !== 2'(i / 8)) begin
        $display("FAIL req_coord frame %0d got (%0d,%0d) want (%0d,%0d)", k, bus.ray_x_out, bus.ray_y_out, i % 8, i / 8); errors++; end
      bus.ray_ready_in = 1'b1;
      bus.new_frame_in = (i == nf_at);
      @(negedge clk);
      bus.ray_ready_in = 1'b0;
      bus.new_frame_in = 1'b0;
      vectors++; if (bus.ray_valid_out !== 1'b0) begin $display("FAIL valid_drop frame %0d pixel %0d got %b want 0", k, i, bus.ray_valid_out); errors++; end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      bus.pix_valid_in = 1'b1;
      bus.pix_data_in = frames[k][i];
      bus.new_frame_in = nf_last && i == NPIX - 1;
      @(negedge clk);
      bus.pix_valid_in = 1'b0;
      bus.new_frame_in = 1'b0;
      ea = 6'((k % 2) * 32 + i);
      vectors++;
      if (bus.wr_en_out !== 1'b1 || bus.wr_addr_out !== ea || bus.wr_data_out !== frames[k][i]) begin
        $display("FAIL write frame %0d pixel %0d got en=%b addr=%0d data=%h want 1/%0d/%h",
                 k, i, bus.wr_en_out, bus.wr_addr_out, bus.wr_data_out, ea, frames[k][i]); errors++; end
    end
    vectors++; if (bus.busy_out !== 1'b0) begin $display("FAIL done_busy frame %0d got %b want 0", k, bus.busy_out); errors++; end
    @(negedge clk);
    vectors++; if (bus.wr_en_out !== 1'b0 || bus.busy_out !== 1'b0) begin
      $display("FAIL done_idle frame %0d got en=%b busy=%b want 0/0", k, bus.wr_en_out, bus.busy_out); errors++; end
  endtask

  task automatic check_display(input int sf, input int db, input int n);
    logic [23:0] exp_rgb[$];
    logic [23:0] e;
    logic [5:0]  ea;
    int h, v, idx;
    bit inf;
    for (int c = 0; c < n + 3; c++) begin
      h = 100; v = 100;
      if (c < n) begin h = $urandom_range(0, 19); v = $urandom_range(0, 9); end
      bus.hcount_in = 11'(h);
      bus.vcount_in = 10'(v);
      inf = h < W && v < H;
      idx = inf ? h / S + 8 * (v / S) : 0;
      exp_rgb.push_back((inf && sf >= 0) ? frames[sf < 0 ? 0 : sf][idx] : 24'h0);
      ea = inf ? 6'(db * 32 + idx) : 6'h0;
      @(negedge clk);
      vectors++; if (bus.rd_addr_out !== ea) begin $display("FAIL rd_addr h=%0d v=%0d got %0d want %0d", h, v, bus.rd_addr_out, ea); errors++; end
      if (c >= 3) begin
        e = exp_rgb.pop_front();
        vectors++;
        if ({bus.red_out, bus.green_out, bus.blue_out} !== e) begin
          $display("FAIL rgb step %0d got %h want %h", c, {bus.red_out, bus.green_out, bus.blue_out}, e); errors++; end
      end
    end
  endtask

  task automatic test_swap(input int fc);
    bus.new_frame_in = 1'b1;
    @(negedge clk);
    bus.new_frame_in = 1'b0;
    vectors++; if (bus.frame_count_out !== 16'(fc)) begin $display("FAIL swap_count got %0d want %0d", bus.frame_count_out, fc); errors++; end
    vectors++; if (bus.busy_out !== 1'b1 || bus.ray_valid_out !== 1'b1) begin
      $display("FAIL swap_restart got busy=%b valid=%b want 1/1", bus.busy_out, bus.ray_valid_out); errors++; end
  endtask

  task automatic test_stall();
    for (int c = 0; c < 5; c++) begin
      vectors++;
      if (bus.ray_valid_out !== 1'b1 || bus.ray_x_out !== 3'd0 || bus.ray_y_out !== 2'd0 || bus.wr_en_out !== 1'b0) begin
        $display("FAIL stall cycle %0d got valid=%b x=%0d y=%0d en=%b want 1/0/0/0", c, bus.ray_valid_out, bus.ray_x_out, bus.ray_y_out, bus.wr_en_out); errors++; end
      @(negedge clk);
    end
    bus.pix_valid_in = 1'b1;
    bus.pix_data_in = 24'hABCDEF;
    @(negedge clk);
    bus.pix_valid_in = 1'b0;
    vectors++; if (bus.wr_en_out !== 1'b0) begin $display("FAIL issue_pix_ignored got en=%b want 0", bus.wr_en_out); errors++; end
  endtask

  task automatic test_no_swap();
    vectors++; if (bus.frame_count_out !== 16'd1 || bus.busy_out !== 1'b0) begin
      $display("FAIL no_swap got fc=%0d busy=%b want 1/0", bus.frame_count_out, bus.busy_out); errors++; end
    check_display(0, 0, 16);
  endtask

  task automatic test_async_reset();
    bit ok;
    bus.hcount_in = 11'd0;
    bus.vcount_in = 10'd0;
    for (int i = 0; i < 3; i++) begin
      wait_valid(ok);
      bus.ray_ready_in = 1'b1;
      @(negedge clk);
      bus.ray_ready_in = 1'b0;
      bus.pix_valid_in = 1'b1;
      bus.pix_data_in = frames[2][i];
      @(negedge clk);
      bus.pix_valid_in = 1'b0;
    end
    wait_valid(ok);
    vectors++; if (!ok) begin $display("FAIL arst_req_timeout got valid=%b want 1", bus.ray_valid_out); errors++; end
    bus.ray_ready_in = 1'b1;
    @(negedge clk);
    bus.ray_ready_in = 1'b0;
    vectors++; if ({bus.red_out, bus.green_out, bus.blue_out} !== frames[1][0]) begin
      $display("FAIL pre_reset_rgb got %h want %h", {bus.red_out, bus.green_out, bus.blue_out}, frames[1][0]); errors++; end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (bus.ray_valid_out !== 1'b0 || bus.wr_addr_out !== 6'd0 || bus.frame_count_out !== 16'd0) begin
      $display("FAIL arst_clear got valid=%b addr=%0d fc=%0d want 0/0/0", bus.ray_valid_out, bus.wr_addr_out, bus.frame_count_out); errors++; end
    vectors++; if ({bus.red_out, bus.green_out, bus.blue_out} !== 24'd0 || bus.busy_out !== 1'b1 || bus.rd_addr_out !== 6'd0) begin
      $display("FAIL arst_display got rgb=%h busy=%b rd_addr=%0d want 0/1/0", {bus.red_out, bus.green_out, bus.blue_out}, bus.busy_out, bus.rd_addr_out); errors++; end
    @(negedge clk);
    rst_n = 1'b1;
    bus.pix_valid_in = 1'b1;
    bus.pix_data_in = 24'h123456;
    @(negedge clk);
    bus.pix_valid_in = 1'b0;
    vectors++; if (bus.wr_en_out !== 1'b0) begin $display("FAIL arst_pix_ignored got en=%b want 0", bus.wr_en_out); errors++; end
    vectors++; if (bus.rd_addr_out !== 6'd32) begin $display("FAIL arst_rd_bank got %0d want 32", bus.rd_addr_out); errors++; end
    wait_valid(ok);
    vectors++; if (!ok || bus.ray_x_out !== 3'd0 || bus.ray_y_out !== 2'd0) begin
      $display("FAIL arst_first_req got valid=%b (%0d,%0d) want 1 (0,0)", bus.ray_valid_out, bus.ray_x_out, bus.ray_y_out); errors++; end
    repeat (3) @(negedge clk);
    vectors++; if ({bus.red_out, bus.green_out, bus.blue_out} !== 24'd0) begin
      $display("FAIL arst_black got %h want 0", {bus.red_out, bus.green_out, bus.blue_out}); errors++; end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired after %0d vectors", vectors);
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < NPIX; i++) frames[k][i] = 24'($urandom);
    test_reset();
    render_frame(0, -1, 1'b0);
    check_display(-1, 1, 8);
    test_swap(1);
    check_display(0, 0, 24);
    test_stall();
    render_frame(1, 10, 1'b1);
    test_no_swap();
    test_swap(2);
    check_display(1, 1, 16);
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
